threefish_sequencer: RTL and testbench

THREEFISH_SEQUENCER -- requirements
Module: threefish_sequencer

---
 rtl/threefish_pkg.sv | 16 +
 rtl/threefish_sequencer_phase_counter.sv | 27 ++
 rtl/threefish_sequencer.sv | 118 +++++++++++
 tb/tb_threefish_sequencer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/threefish_pkg.sv
// Shared Threefish types and default sizing used by the sequencer, key schedule and MIX datapath.
package threefish_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        KEYGEN = 3'd1,
        KEYADD = 3'd2,
        ROUND  = 3'd3,
        DONE   = 3'd4
    } mode_t;

    localparam int DEFAULT_WORDS          = 16;
    localparam int DEFAULT_ROUNDS_PER_KEY = 4;
    localparam int DEFAULT_NUM_ROUNDS     = 80;

endpackage

// File: rtl/threefish_sequencer_phase_counter.sv
// Word counter for one phase: counts inc pulses from 0 to MAX_COUNT, then wraps to 0.
module phase_counter #(
    parameter int WIDTH     = 4,
    parameter int MAX_COUNT = (1 << WIDTH) - 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count,
    output logic             last
);

    assign last = (count == WIDTH'(MAX_COUNT));

    // clear wins over inc so an abort or a fresh start always lands on word 0
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= last ? '0 : count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/threefish_sequencer.sv
// Threefish block sequencer: steps KEYGEN/KEYADD/ROUND phases one word per advance.
// Optional abort input enabled by defining THREEFISH_SEQ_ABORT_EN.
module threefish_sequencer
    import threefish_pkg::*;
#(
    parameter int WORDS          = DEFAULT_WORDS,
    parameter int ROUNDS_PER_KEY = DEFAULT_ROUNDS_PER_KEY,
    parameter int NUM_ROUNDS     = DEFAULT_NUM_ROUNDS
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,
    input  logic                                          start_i,
    input  logic                                          advance_i,
`ifdef THREEFISH_SEQ_ABORT_EN
    input  logic                                          abort_i,
`endif
    output logic [2:0]                                    mode_o,
    output logic [$clog2(WORDS)-1:0]                      word_idx_o,
    output logic [$clog2(NUM_ROUNDS+1)-1:0]               round_o,
    output logic [$clog2(NUM_ROUNDS/ROUNDS_PER_KEY+1)-1:0] subkey_idx_o,
    output logic                                          busy_o,
    output logic                                          done_o
);

    localparam int WW = $clog2(WORDS);
    localparam int RW = $clog2(NUM_ROUNDS + 1);
    localparam int SW = $clog2(NUM_ROUNDS / ROUNDS_PER_KEY + 1);

    if (NUM_ROUNDS % ROUNDS_PER_KEY != 0) begin : g_bad_cfg
        $error("NUM_ROUNDS must be an integer multiple of ROUNDS_PER_KEY");
    end

    mode_t          state_q, state_d;
    logic [RW-1:0]  round_q;
    logic [SW-1:0]  subkey_q;
    logic [RW-1:0]  round_next;
    logic           word_last;
    logic           advance_ok;
    logic           phase_end;
    logic           clear_all;
    logic           abort_req;
    logic           key_boundary;

`ifdef THREEFISH_SEQ_ABORT_EN
    assign abort_req = abort_i && (state_q != IDLE);
`else
    assign abort_req = 1'b0;
`endif

    assign advance_ok   = advance_i && (state_q inside {KEYGEN, KEYADD, ROUND});
    assign phase_end    = advance_ok && word_last;
    assign round_next   = round_q + RW'(1);
    assign key_boundary = ((int'(round_next) % ROUNDS_PER_KEY) == 0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clear_all = 1'b0;
        if (abort_req) begin
            state_d   = IDLE;
            clear_all = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_d   = KEYGEN;
                        clear_all = 1'b1;
                    end
                end
                KEYGEN: if (phase_end) state_d = KEYADD;
                // the final subkey follows the last round, so DONE is decided here
                KEYADD: if (phase_end) state_d = (round_q == RW'(NUM_ROUNDS)) ? DONE : ROUND;
                ROUND:  if (phase_end && key_boundary) state_d = KEYGEN;
                DONE:   state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            round_q  <= '0;
            subkey_q <= '0;
        end else if (clear_all) begin
            round_q  <= '0;
            subkey_q <= '0;
        end else if (phase_end) begin
            if (state_q == KEYADD) subkey_q <= subkey_q + SW'(1);
            if (state_q == ROUND)  round_q  <= round_next;
        end
    end

    phase_counter #(
        .WIDTH     (WW),
        .MAX_COUNT (WORDS - 1)
    ) u_word_counter (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clear  (clear_all),
        .inc    (advance_ok),
        .count  (word_idx_o),
        .last   (word_last)
    );

    assign mode_o       = state_q;
    assign round_o      = round_q;
    assign subkey_idx_o = subkey_q;
    assign busy_o       = (state_q != IDLE);
    assign done_o       = (state_q == DONE);

endmodule

// File: tb/tb_threefish_sequencer.sv
// Directed bench for threefish_sequencer: default and small configurations, stalls, reset, start/abort.
module tb_threefish_sequencer;
  import threefish_pkg::*;

  localparam int W   = 16;
  localparam int RPK = 4;
  localparam int NR  = 80;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- default-configuration DUT ----------------
  logic       start, advance;
  logic [2:0] mode;
  logic [3:0] word;
  logic [6:0] round;
  logic [4:0] sub;
  logic       busy, done;
`ifdef THREEFISH_SEQ_ABORT_EN
  logic       abort;
`endif

  threefish_sequencer #(.WORDS(W), .ROUNDS_PER_KEY(RPK), .NUM_ROUNDS(NR)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .advance_i(advance),
`ifdef THREEFISH_SEQ_ABORT_EN
    .abort_i(abort),
`endif
    .mode_o(mode), .word_idx_o(word), .round_o(round), .subkey_idx_o(sub),
    .busy_o(busy), .done_o(done)
  );

  // ---------------- small-configuration DUT ----------------
  logic       s_start, s_advance;
  logic [2:0] s_mode;
  logic [0:0] s_word;
  logic [2:0] s_round;
  logic [1:0] s_sub;
  logic       s_busy, s_done;
`ifdef THREEFISH_SEQ_ABORT_EN
  logic       s_abort;
`endif

  threefish_sequencer #(.WORDS(2), .ROUNDS_PER_KEY(2), .NUM_ROUNDS(4)) dut_small (
    .clk_i(clk), .rst_ni(rst_n), .start_i(s_start), .advance_i(s_advance),
`ifdef THREEFISH_SEQ_ABORT_EN
    .abort_i(s_abort),
`endif
    .mode_o(s_mode), .word_idx_o(s_word), .round_o(s_round), .subkey_idx_o(s_sub),
    .busy_o(s_busy), .done_o(s_done)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [2:0] exp_q[$];
  logic [2:0] got_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model (default configuration) ----------------
  int m_mode, m_word, m_round, m_sub;

  task automatic model_advance();
    if (m_mode >= 1 && m_mode <= 3) begin
      if (m_word == W - 1) begin
        m_word = 0;
        case (m_mode)
          1: m_mode = 2;
          2: begin
            m_sub++;
            m_mode = (m_round == NR) ? 4 : 3;
          end
          default: begin
            m_round++;
            if (m_round % RPK == 0) m_mode = 1;
          end
        endcase
      end else begin
        m_word++;
      end
    end
  endtask

  // ---------------- driver ----------------
  // Starts a block, then compares the DUT against the model every cycle until done_o.
  task automatic run_block(input int duty, input int start_at, output int kg_to_done, output int mism);
    bit adv;
    @(negedge clk);
    start = 1'b1;
    advance = 1'b0;
    @(negedge clk);
    start = 1'b0;
    m_mode = 1; m_word = 0; m_round = 0; m_sub = 0;
    kg_to_done = -1;
    mism = 0;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      if (mode !== 3'(m_mode) || word !== 4'(m_word) || round !== 7'(m_round) || sub !== 5'(m_sub))
        mism++;
      if (done === 1'b1) begin
        kg_to_done = cyc;
        break;
      end
      start = (cyc == start_at);
      adv = ($urandom_range(99) < duty);
      advance = adv;
      if (adv) model_advance();
      @(negedge clk);
    end
    start = 1'b0;
    advance = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  int kg_to_done, mism, adv_cnt;
  bit found, done_seen;

  initial begin
    start = 0; advance = 0; s_start = 0; s_advance = 0;
`ifdef THREEFISH_SEQ_ABORT_EN
    abort = 0; s_abort = 0;
`endif
    repeat (3) @(negedge clk);
    check("rst_mode", mode, 0);
    check("rst_word", word, 0);
    check("rst_round", round, 0);
    check("rst_sub", sub, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_mode", mode, 0);

    // small configuration: phase sequence and advance count
    exp_q = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd1, 3'd2, 3'd3, 3'd3, 3'd1, 3'd2, 3'd4};
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    s_advance = 1'b1;
    adv_cnt = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (s_done === 1'b1) begin
        got_q.push_back(s_mode);
        break;
      end
      if (s_mode >= 3'd1 && s_mode <= 3'd3) begin
        adv_cnt++;
        if (s_word == 1'b0) got_q.push_back(s_mode);
      end
      @(negedge clk);
    end
    s_advance = 1'b0;
    check("small_phase_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("small_phase_%0d", i), got_q[i], exp_q[i]);
    check("small_advances", adv_cnt, 20);
    check("small_round", s_round, 4);
    check("small_sub", s_sub, 3);
    @(negedge clk);
    check("small_idle_after_done", s_mode, 0);

    // full-rate block with start pulsed mid-ROUND (cycle 40) and again in DONE
    run_block(100, 40, kg_to_done, mism);
    check("full_kg_to_done", kg_to_done, 1952);
    check("full_trace_mism", mism, 0);
    check("full_round", round, 80);
    check("full_sub", sub, 21);
    check("full_busy_in_done", busy, 1);
    start = 1'b1;
    advance = 1'b1;
    @(negedge clk);
    start = 1'b0;
    advance = 1'b0;
    check("after_done_mode", mode, 0);
    check("after_done_done", done, 0);
    check("after_done_busy", busy, 0);
    check("after_done_round_held", round, 80);
    @(negedge clk);
    check("start_in_done_ignored", mode, 0);

    // 30% advance duty: same trace once stalls are removed
    run_block(30, -1, kg_to_done, mism);
    check("stall_done_seen", (kg_to_done >= 1952) ? 1 : 0, 1);
    check("stall_trace_mism", mism, 0);
    @(negedge clk);

    // asynchronous reset mid-block at round 37, word 9
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    advance = 1'b1;
    found = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (round == 7'd37 && word == 4'd9) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check("rst_point_reached", found, 1);
    check("rst_point_mode", mode, 3);
    rst_n = 1'b0;
    #1;
    check("async_rst_mode", mode, 0);
    check("async_rst_word", word, 0);
    check("async_rst_round", round, 0);
    check("async_rst_sub", sub, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_done", done, 0);
    advance = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_block(100, -1, kg_to_done, mism);
    check("post_rst_kg_to_done", kg_to_done, 1952);
    check("post_rst_trace_mism", mism, 0);
    @(negedge clk);

`ifdef THREEFISH_SEQ_ABORT_EN
    // abort with advance and start in KEYADD
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    advance = 1'b1;
    found = 0;
    done_seen = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (mode == 3'd2 && word == 4'd5) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check("abort_point_reached", found, 1);
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    advance = 1'b0;
    check("abort_mode", mode, 0);
    check("abort_word", word, 0);
    check("abort_round", round, 0);
    check("abort_sub", sub, 0);
    check("abort_busy", busy, 0);
    for (int cyc = 0; cyc < 5; cyc++) begin
      if (done === 1'b1) done_seen = 1;
      @(negedge clk);
    end
    check("abort_no_done", done_seen, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
